// File: rtl/qracc_sram_arbiter.sv
// Round-robin arbiter sharing one QRAcc SRAM bank port between numReq requesters.
// One transaction (including read-data return) is in flight at a time; grants pause while the MAC runs.
module qracc_sram_arbiter #(
    parameter int numRows = 128,
    parameter int numCols = 32,
    parameter int numReq  = 2,
    localparam int AW     = $clog2(numRows),
    localparam int IW     = $clog2(numReq)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mac_busy_i,
    input  logic [numReq-1:0]         req_valid_i,
    input  logic [numReq-1:0]         req_wr_i,
    input  logic [numReq*AW-1:0]      req_addr_i,
    input  logic [numReq*numCols-1:0] req_wdata_i,
    output logic [numReq-1:0]         req_ready_o,
    output logic [numReq-1:0]         rsp_valid_o,
    output logic [numCols-1:0]        rsp_rdata_o,
    output logic                      sram_rq_valid_o,
    output logic                      sram_rq_wr_o,
    output logic [AW-1:0]             sram_addr_o,
    output logic [numCols-1:0]        sram_wr_data_o,
    input  logic                      sram_rq_ready_i,
    input  logic                      sram_rd_valid_i,
    input  logic [numCols-1:0]        sram_rd_data_i,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [IW-1:0]        grant_idx_q, grant_idx_d;
    logic                 hold_wr_q, hold_wr_d;
    logic [AW-1:0]        hold_addr_q, hold_addr_d;
    logic [numCols-1:0]   hold_wdata_q, hold_wdata_d;
    logic                 sram_rq_valid_q, sram_rq_valid_d;
    logic                 busy_q, busy_d;
    logic [numReq-1:0]    rsp_valid_q, rsp_valid_d;
    logic [numCols-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                 found_s;
    logic [IW-1:0]        winner_s;
    logic                 grant_s;
    logic [numReq-1:0]    req_ready_s;

    // Round-robin search upward from the requester after the last winner
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IW{1'b0}};
        for (int k = 1; k <= numReq; k++) begin
            automatic int cand = (int'(last_grant_q) + k) % numReq;
            if (!found_s && req_valid_i[cand]) begin
                found_s  = 1'b1;
                winner_s = IW'(cand);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant pulse; gated by rst so a request is never acknowledged and then lost to reset
    always_comb begin
        req_ready_s = {numReq{1'b0}};
        grant_s     = (state_q == IDLE) && !mac_busy_i && found_s && !rst;
        if (grant_s) begin
            req_ready_s[winner_s] = 1'b1;
        end else begin
            req_ready_s = {numReq{1'b0}};
        end
    end

    // Next-state and next-output computation
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_idx_d     = grant_idx_q;
        hold_wr_d       = hold_wr_q;
        hold_addr_d     = hold_addr_q;
        hold_wdata_d    = hold_wdata_q;
        sram_rq_valid_d = sram_rq_valid_q;
        busy_d          = busy_q;
        rsp_valid_d     = {numReq{1'b0}};
        rsp_rdata_d     = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    hold_wr_d       = req_wr_i[winner_s];
                    hold_addr_d     = req_addr_i[int'(winner_s)*AW +: AW];
                    hold_wdata_d    = req_wdata_i[int'(winner_s)*numCols +: numCols];
                    grant_idx_d     = winner_s;
                    last_grant_d    = winner_s;
                    state_d         = ISSUE;
                    sram_rq_valid_d = 1'b1;
                    busy_d          = 1'b1;
                end else begin
                    sram_rq_valid_d = 1'b0;
                    busy_d          = 1'b0;
                end
            end
            ISSUE: begin
                if (sram_rq_ready_i) begin
                    sram_rq_valid_d = 1'b0;
                    if (hold_wr_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = WAIT_RD;
                        busy_d  = 1'b1;
                    end
                end else begin
                    sram_rq_valid_d = 1'b1;
                    busy_d          = 1'b1;
                end
            end
            WAIT_RD: begin
                if (sram_rd_valid_i) begin
                    rsp_rdata_d              = sram_rd_data_i;
                    rsp_valid_d[grant_idx_q] = 1'b1;
                    state_d                  = IDLE;
                    busy_d                   = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d         = IDLE;
                sram_rq_valid_d = 1'b0;
                busy_d          = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_grant_q    <= IW'(numReq - 1);
            grant_idx_q     <= {IW{1'b0}};
            hold_wr_q       <= 1'b0;
            hold_addr_q     <= {AW{1'b0}};
            hold_wdata_q    <= {numCols{1'b0}};
            sram_rq_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            rsp_valid_q     <= {numReq{1'b0}};
            rsp_rdata_q     <= {numCols{1'b0}};
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_idx_q     <= grant_idx_d;
            hold_wr_q       <= hold_wr_d;
            hold_addr_q     <= hold_addr_d;
            hold_wdata_q    <= hold_wdata_d;
            sram_rq_valid_q <= sram_rq_valid_d;
            busy_q          <= busy_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
        end
    end

    assign req_ready_o     = req_ready_s;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign sram_rq_valid_o = sram_rq_valid_q;
    assign sram_rq_wr_o    = hold_wr_q;
    assign sram_addr_o     = hold_addr_q;
    assign sram_wr_data_o  = hold_wdata_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Self-checking bench for qracc_sram_arbiter: directed scenarios on 2- and 4-requester
// instances plus a randomized run checked against a transaction-level model.
module tb_qracc_sram_arbiter;

    localparam int AW = 7;
    localparam int W  = 32;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           mac;
    logic [1:0]     rv, rw, rdy, rspv;
    logic [2*AW-1:0] ra;
    logic [2*W-1:0] rd;
    logic [W-1:0]   rsp_data, swd, srdd;
    logic           sv, swr, srr, srdv, busy;
    logic [AW-1:0]  saddr;

    logic           mac4;
    logic [3:0]     rv4, rw4, rdy4, rspv4;
    logic [4*AW-1:0] ra4;
    logic [4*W-1:0] rd4;
    logic [W-1:0]   rsp_data4, swd4, srdd4;
    logic           sv4, swr4, srr4, srdv4, busy4;
    logic [AW-1:0]  saddr4;

    qracc_sram_arbiter #(.numRows(128), .numCols(W), .numReq(2)) dut (
        .clk(clk), .rst(rst), .mac_busy_i(mac),
        .req_valid_i(rv), .req_wr_i(rw), .req_addr_i(ra), .req_wdata_i(rd),
        .req_ready_o(rdy), .rsp_valid_o(rspv), .rsp_rdata_o(rsp_data),
        .sram_rq_valid_o(sv), .sram_rq_wr_o(swr), .sram_addr_o(saddr), .sram_wr_data_o(swd),
        .sram_rq_ready_i(srr), .sram_rd_valid_i(srdv), .sram_rd_data_i(srdd), .busy_o(busy)
    );

    qracc_sram_arbiter #(.numRows(128), .numCols(W), .numReq(4)) dut4 (
        .clk(clk), .rst(rst), .mac_busy_i(mac4),
        .req_valid_i(rv4), .req_wr_i(rw4), .req_addr_i(ra4), .req_wdata_i(rd4),
        .req_ready_o(rdy4), .rsp_valid_o(rspv4), .rsp_rdata_o(rsp_data4),
        .sram_rq_valid_o(sv4), .sram_rq_wr_o(swr4), .sram_addr_o(saddr4), .sram_wr_data_o(swd4),
        .sram_rq_ready_i(srr4), .sram_rd_valid_i(srdv4), .sram_rd_data_i(srdd4), .busy_o(busy4)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_in();
        rv = 2'b00; rw = 2'b00; ra = '0; rd = '0; mac = 1'b0;
        srr = 1'b0; srdv = 1'b0; srdd = '0;
        mac4 = 1'b0; rv4 = 4'b0000; rw4 = 4'b0000; ra4 = '0; rd4 = '0;
        srr4 = 1'b0; srdv4 = 1'b0; srdd4 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        nxt();
        nxt();
        smp();
        checks++; if (rdy !== 2'b00)    begin errors++; $display("FAIL rst_ready got %b want 00", rdy); end
        checks++; if (rspv !== 2'b00)   begin errors++; $display("FAIL rst_rsp_valid got %b want 00", rspv); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rsp_data); end
        checks++; if (sv !== 1'b0)      begin errors++; $display("FAIL rst_rq_valid got %b want 0", sv); end
        checks++; if (swr !== 1'b0)     begin errors++; $display("FAIL rst_rq_wr got %b want 0", swr); end
        checks++; if (saddr !== 7'h0)   begin errors++; $display("FAIL rst_addr got %h want 0", saddr); end
        checks++; if (swd !== 32'h0)    begin errors++; $display("FAIL rst_wdata got %h want 0", swd); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL rst_busy4 got %b want 0", busy4); end
        rv = 2'b11;
        smp();
        checks++; if (rdy !== 2'b00)    begin errors++; $display("FAIL rst_ready_gated got %b want 00", rdy); end
        rv = 2'b00;
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        rv = 2'b01; rw = 2'b00; ra[6:0] = 7'd5;
        smp();
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL sr_grant got %b want 01", rdy); end
        nxt();
        rv = 2'b00; srr = 1'b1;
        smp();
        checks++; if (sv !== 1'b1)     begin errors++; $display("FAIL sr_rq_valid got %b want 1", sv); end
        checks++; if (saddr !== 7'd5)  begin errors++; $display("FAIL sr_addr got %h want 05", saddr); end
        checks++; if (swr !== 1'b0)    begin errors++; $display("FAIL sr_wr got %b want 0", swr); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL sr_busy got %b want 1", busy); end
        nxt();
        srr = 1'b0;
        smp();
        checks++; if (sv !== 1'b0)     begin errors++; $display("FAIL sr_rq_drop got %b want 0", sv); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL sr_busy_wait got %b want 1", busy); end
        nxt();
        srdv = 1'b1; srdd = 32'hDEADBEEF;
        smp();
        checks++; if (rspv !== 2'b00)  begin errors++; $display("FAIL sr_rsp_early got %b want 00", rspv); end
        nxt();
        srdv = 1'b0; srdd = 32'h0;
        smp();
        checks++; if (rspv !== 2'b01)  begin errors++; $display("FAIL sr_rsp_valid got %b want 01", rspv); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata got %h want deadbeef", rsp_data); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL sr_busy_done got %b want 0", busy); end
        nxt();
        smp();
        checks++; if (rspv !== 2'b00)  begin errors++; $display("FAIL sr_rsp_once got %b want 00", rspv); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata_hold got %h want deadbeef", rsp_data); end
        nxt();
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 1, 0, 1};
        logic [1:0]    exp_rdy;
        logic [AW-1:0] exp_addr;
        logic [W-1:0]  exp_data;
        do_reset();
        rv = 2'b11; rw = 2'b11;
        ra[6:0] = 7'h10; ra[13:7] = 7'h20;
        rd[31:0] = 32'hA0A0_0000; rd[63:32] = 32'hB1B1_0000;
        srr = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_rdy  = 2'b01 << order[g];
            exp_addr = (order[g] == 1) ? 7'h20 : 7'h10;
            exp_data = (order[g] == 1) ? 32'hB1B1_0000 : 32'hA0A0_0000;
            smp();
            checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b want %b", g, rdy, exp_rdy); end
            nxt();
            smp();
            checks++; if (rdy !== 2'b00)   begin errors++; $display("FAIL rr_gap%0d got %b want 00", g, rdy); end
            checks++; if (sv !== 1'b1 || saddr !== exp_addr || swd !== exp_data)
                begin errors++; $display("FAIL rr_issue%0d got v=%b a=%h d=%h want v=1 a=%h d=%h", g, sv, saddr, swd, exp_addr, exp_data); end
            nxt();
        end
        rv = 2'b00; srr = 1'b0;
    endtask

    task automatic test_backpressure();
        rv = 2'b01; rw = 2'b01; ra[6:0] = 7'h7F; rd[31:0] = 32'hA5A5_5A5A; srr = 1'b0;
        smp();
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL bp_grant got %b want 01", rdy); end
        nxt();
        rv = 2'b10; rw = 2'b11; ra[6:0] = 7'h00; rd[31:0] = 32'h0;
        ra[13:7] = 7'h33; rd[63:32] = 32'h0BAD_F00D;
        for (int c = 0; c < 5; c++) begin
            smp();
            checks++; if (sv !== 1'b1 || saddr !== 7'h7F || swd !== 32'hA5A5_5A5A || swr !== 1'b1)
                begin errors++; $display("FAIL bp_hold%0d got v=%b a=%h d=%h w=%b want v=1 a=7f d=a5a55a5a w=1", c, sv, saddr, swd, swr); end
            checks++; if (rdy !== 2'b00) begin errors++; $display("FAIL bp_no_grant%0d got %b want 00", c, rdy); end
            nxt();
        end
        srr = 1'b1;
        smp();
        checks++; if (sv !== 1'b1) begin errors++; $display("FAIL bp_hs_valid got %b want 1", sv); end
        nxt();
        srr = 1'b0;
        smp();
        checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL bp_next_grant got %b want 10", rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", busy); end
        nxt();
        rv = 2'b00; srr = 1'b1;
        smp();
        checks++; if (saddr !== 7'h33) begin errors++; $display("FAIL bp_second_addr got %h want 33", saddr); end
        nxt();
        srr = 1'b0;
    endtask

    task automatic test_mac_block();
        rv = 2'b01; rw = 2'b00; ra[6:0] = 7'd3;
        smp();
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL mb_grant_rd got %b want 01", rdy); end
        nxt();
        rv = 2'b10; rw = 2'b10; ra[13:7] = 7'd9; rd[63:32] = 32'hCAFE_0009; mac = 1'b1; srr = 1'b1;
        smp();
        checks++; if (rdy !== 2'b00) begin errors++; $display("FAIL mb_hold_issue got %b want 00", rdy); end
        nxt();
        srr = 1'b0;
        smp();
        checks++; if (rdy !== 2'b00) begin errors++; $display("FAIL mb_hold_wait got %b want 00", rdy); end
        nxt();
        srdv = 1'b1; srdd = 32'h1234_5678;
        smp();
        nxt();
        srdv = 1'b0;
        smp();
        checks++; if (rspv !== 2'b01 || rsp_data !== 32'h1234_5678)
            begin errors++; $display("FAIL mb_rsp got v=%b d=%h want v=01 d=12345678", rspv, rsp_data); end
        checks++; if (rdy !== 2'b00) begin errors++; $display("FAIL mb_blocked_idle got %b want 00", rdy); end
        for (int c = 0; c < 2; c++) begin
            nxt();
            smp();
            checks++; if (rdy !== 2'b00) begin errors++; $display("FAIL mb_blocked%0d got %b want 00", c, rdy); end
        end
        nxt();
        mac = 1'b0;
        smp();
        checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL mb_release got %b want 10", rdy); end
        nxt();
        rv = 2'b00; srr = 1'b1;
        smp();
        checks++; if (sv !== 1'b1 || saddr !== 7'd9) begin errors++; $display("FAIL mb_issue got v=%b a=%h want v=1 a=09", sv, saddr); end
        nxt();
        srr = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        rv = 2'b01; rw = 2'b00; ra[6:0] = 7'h11;
        smp();
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL rm_grant got %b want 01", rdy); end
        nxt();
        rv = 2'b00; srr = 1'b1;
        nxt();
        srr = 1'b0; rst = 1'b1;
        smp();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_in_read got %b want 1", busy); end
        nxt();
        rst = 1'b0; srdv = 1'b1; srdd = 32'h5555_AAAA;
        smp();
        checks++; if (rdy !== 2'b00 || rspv !== 2'b00 || rsp_data !== 32'h0 || busy !== 1'b0)
            begin errors++; $display("FAIL rm_rsp_side got r=%b v=%b d=%h b=%b want all 0", rdy, rspv, rsp_data, busy); end
        checks++; if (sv !== 1'b0 || swr !== 1'b0 || saddr !== 7'h0 || swd !== 32'h0)
            begin errors++; $display("FAIL rm_sram_side got v=%b w=%b a=%h d=%h want all 0", sv, swr, saddr, swd); end
        nxt();
        srdv = 1'b0; srdd = 32'h0;
        smp();
        checks++; if (rspv !== 2'b00) begin errors++; $display("FAIL rm_no_stale_rsp got %b want 00", rspv); end
        nxt();
        rv = 2'b11; rw = 2'b11;
        smp();
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL rm_first_req0 got %b want 01", rdy); end
        nxt();
        rv = 2'b00; srr = 1'b1;
        nxt();
        srr = 1'b0;
    endtask

    task automatic test_num4();
        int seq[4] = '{3, 0, 1, 2};
        logic [3:0] exp4;
        srr4 = 1'b1; rw4 = 4'hF; rv4 = 4'b0100;
        smp();
        checks++; if (rdy4 !== 4'b0100) begin errors++; $display("FAIL n4_seed got %b want 0100", rdy4); end
        nxt();
        rv4 = 4'hF;
        smp();
        checks++; if (rdy4 !== 4'b0000 || busy4 !== 1'b1) begin errors++; $display("FAIL n4_issue got r=%b b=%b want r=0000 b=1", rdy4, busy4); end
        for (int g = 0; g < 4; g++) begin
            exp4 = 4'b0001 << seq[g];
            nxt();
            smp();
            checks++; if (rdy4 !== exp4) begin errors++; $display("FAIL n4_grant%0d got %b want %b", g, rdy4, exp4); end
            nxt();
            smp();
            checks++; if (rdy4 !== 4'b0000) begin errors++; $display("FAIL n4_gap%0d got %b want 0000", g, rdy4); end
        end
        nxt();
        rv4 = 4'b0000; srr4 = 1'b0;
    endtask

    // Transaction-level model: pending requests, one outstanding transaction, a memory array
    task automatic test_random(int ncyc);
        logic          pend[2];
        logic          pwr[2];
        logic [AW-1:0] paddr[2];
        logic [W-1:0]  pdata[2];
        logic [W-1:0]  mem[128];
        int            last;
        logic          o_v, o_wr, o_acc;
        int            o_who, rd_wait, win;
        logic [AW-1:0] o_addr;
        logic [W-1:0]  o_data;
        logic          rsp_due, new_due, rdv_now, rq_rdy_now;
        int            rsp_who;
        logic [W-1:0]  rsp_exp;
        logic [1:0]    exp_rdy, exp_rspv;
        for (int a = 0; a < 128; a++) mem[a] = $urandom;
        do_reset();
        last = 1; o_v = 1'b0; o_acc = 1'b0; o_wr = 1'b0; o_who = 0; o_addr = '0; o_data = '0;
        rd_wait = 0; rsp_due = 1'b0; rsp_who = 0; rsp_exp = '0;
        for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; pwr[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; end
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    pwr[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = 7'($urandom_range(0, 7));
                    pdata[i] = $urandom;
                end
                rv[i] = pend[i];
                rw[i] = pwr[i];
                ra[i*AW +: AW] = paddr[i];
                rd[i*W +: W]   = pdata[i];
            end
            mac = ($urandom_range(0, 4) == 0);
            rq_rdy_now = 1'($urandom_range(0, 1));
            srr = rq_rdy_now;
            rdv_now = 1'b0;
            if (o_v && !o_wr && o_acc) begin
                if (rd_wait == 0) rdv_now = 1'b1;
                else rd_wait--;
            end else begin
                rdv_now = ($urandom_range(0, 7) == 0);
            end
            srdv = rdv_now;
            srdd = (o_v && !o_wr && o_acc && rdv_now) ? mem[o_addr] : $urandom;
            win = -1;
            if (!o_v && !mac) begin
                for (int k = 1; k <= 2; k++) begin
                    if (win < 0 && pend[(last + k) % 2]) win = (last + k) % 2;
                end
            end
            exp_rdy  = (win >= 0) ? (2'b01 << win) : 2'b00;
            exp_rspv = rsp_due ? (2'b01 << rsp_who) : 2'b00;
            smp();
            checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, rdy, exp_rdy); end
            checks++; if (busy !== o_v)    begin errors++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, o_v); end
            checks++; if (sv !== (o_v && !o_acc)) begin errors++; $display("FAIL rnd_rq_valid c%0d got %b want %b", c, sv, o_v && !o_acc); end
            if (o_v && !o_acc) begin
                checks++; if (saddr !== o_addr || swr !== o_wr || (o_wr && swd !== o_data))
                    begin errors++; $display("FAIL rnd_rq c%0d got a=%h w=%b d=%h want a=%h w=%b d=%h", c, saddr, swr, swd, o_addr, o_wr, o_data); end
            end
            checks++; if (rspv !== exp_rspv) begin errors++; $display("FAIL rnd_rsp_valid c%0d got %b want %b", c, rspv, exp_rspv); end
            if (rsp_due) begin
                checks++; if (rsp_data !== rsp_exp) begin errors++; $display("FAIL rnd_rdata c%0d got %h want %h", c, rsp_data, rsp_exp); end
            end
            nxt();
            new_due = 1'b0;
            if (o_v && o_acc && !o_wr && rdv_now) begin
                new_due = 1'b1; rsp_who = o_who; rsp_exp = mem[o_addr]; o_v = 1'b0;
            end else if (o_v && !o_acc && rq_rdy_now) begin
                o_acc = 1'b1;
                if (o_wr) begin
                    mem[o_addr] = o_data;
                    o_v = 1'b0;
                end else begin
                    rd_wait = $urandom_range(0, 3);
                end
            end
            rsp_due = new_due;
            if (win >= 0) begin
                o_v = 1'b1; o_acc = 1'b0; o_who = win; o_wr = pwr[win];
                o_addr = paddr[win]; o_data = pdata[win];
                pend[win] = 1'b0; last = win;
            end
        end
        clear_in();
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_mac_block();
        test_reset_mid_read();
        test_num4();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
